// File: rtl/softmax_sequencer_if.sv
// softmax_sequencer_if
// Host-facing handshake bundle for the softmax sequencer.
//   in_valid / in_data / in_ready         : input code stream (host -> sequencer)
//   out_valid / out_mant / out_exp /
//   out_last / out_ready                  : result stream (sequencer -> host)
// Modports:
//   master : host side (drives in_valid, in_data, out_ready)
//   slave  : sequencer side (drives in_ready and all out_* except out_ready)
`timescale 1ns/1ps
interface softmax_sequencer_if #(
  parameter int IN_W = 3
);
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [2:0]      out_mant;
  logic [2:0]      out_exp;
  logic            out_last;
  logic            out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_last
  );
endinterface

// File: rtl/softmax_sequencer.sv
// softmax_sequencer
// Front-end controller for the shared pseudo-softmax core. Buffers a vector of
// N_ELEM input codes, issues them to the core one per cycle, captures each
// result CORE_LAT cycles later and streams the results back in input order.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : softmax_sequencer_if.slave (input and result handshakes)
//   busy        : high in ISSUE, DRAIN and OUTPUT
//   core_in     : registered drive to the core input bus
//   core_mant   : core mantissa output
//   core_exp    : core exponent output
`timescale 1ns/1ps
module softmax_sequencer #(
  parameter int N_ELEM   = 4,
  parameter int IN_W     = 3,
  parameter int CORE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  softmax_sequencer_if.slave   bus,
  output logic                 busy,
  output logic [IN_W-1:0]      core_in,
  input  logic [2:0]           core_mant,
  input  logic [2:0]           core_exp
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [IDX_W-1:0]     wr_idx_r;
  logic [IDX_W-1:0]     iss_idx_r;
  logic [IDX_W-1:0]     cap_idx_r;
  logic [IDX_W-1:0]     rd_idx_r;
  logic [CORE_LAT-1:0]  tag_r;
  logic [IN_W-1:0]      core_in_r;
  logic [IN_W-1:0]      inbuf_r  [N_ELEM];
  logic [5:0]           resbuf_r [N_ELEM];

  logic                 in_xfer_s;
  logic                 issue_s;
  logic                 out_xfer_s;
  logic                 capture_s;
  logic                 out_state_s;
  logic [5:0]           rd_word_s;

  // The tag leaving the delay line marks a cycle whose core output belongs to us.
  assign capture_s = tag_r[CORE_LAT-1];

  // Next-state and per-cycle transfer strobes.
  always_comb begin
    state_s    = state_r;
    in_xfer_s  = 1'b0;
    issue_s    = 1'b0;
    out_xfer_s = 1'b0;
    case (state_r)
      LOAD: begin
        in_xfer_s = bus.in_valid;
        if (bus.in_valid && (wr_idx_r == LAST_IDX)) begin
          state_s = ISSUE;
        end else begin
          state_s = LOAD;
        end
      end
      ISSUE: begin
        issue_s = 1'b1;
        if (iss_idx_r == LAST_IDX) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        // All issues are done, so an empty tag line means every result is in.
        if (tag_r == {CORE_LAT{1'b0}}) begin
          state_s = OUTPUT;
        end else begin
          state_s = DRAIN;
        end
      end
      OUTPUT: begin
        out_xfer_s = bus.out_ready;
        if (bus.out_ready && (rd_idx_r == LAST_IDX)) begin
          state_s = LOAD;
        end else begin
          state_s = OUTPUT;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // State, index counters, issue tag line and core drive register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= LOAD;
      wr_idx_r  <= {IDX_W{1'b0}};
      iss_idx_r <= {IDX_W{1'b0}};
      cap_idx_r <= {IDX_W{1'b0}};
      rd_idx_r  <= {IDX_W{1'b0}};
      tag_r     <= {CORE_LAT{1'b0}};
      core_in_r <= {IN_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (in_xfer_s) begin
        wr_idx_r <= wr_idx_r + IDX_W'(1);
      end
      if (issue_s) begin
        iss_idx_r <= iss_idx_r + IDX_W'(1);
      end
      if (capture_s) begin
        cap_idx_r <= cap_idx_r + IDX_W'(1);
      end
      if (out_xfer_s) begin
        rd_idx_r <= rd_idx_r + IDX_W'(1);
      end
      for (int i = CORE_LAT - 1; i > 0; i--) begin
        tag_r[i] <= tag_r[i-1];
      end
      tag_r[0]  <= issue_s;
      core_in_r <= issue_s ? inbuf_r[iss_idx_r] : {IN_W{1'b0}};
    end
  end

  // Data buffers carry no reset; their contents are only read after being written.
  always_ff @(posedge clk) begin
    if (in_xfer_s) begin
      inbuf_r[wr_idx_r] <= bus.in_data;
    end
    if (capture_s) begin
      resbuf_r[cap_idx_r] <= {core_mant, core_exp};
    end
  end

  // Outputs decode the state register, so they follow an asynchronous reset at once.
  assign out_state_s   = (state_r == OUTPUT);
  assign rd_word_s     = resbuf_r[rd_idx_r];
  assign bus.in_ready  = (state_r == LOAD);
  assign bus.out_valid = out_state_s;
  assign bus.out_mant  = out_state_s ? rd_word_s[5:3] : 3'd0;
  assign bus.out_exp   = out_state_s ? rd_word_s[2:0] : 3'd0;
  assign bus.out_last  = out_state_s && (rd_idx_r == LAST_IDX);
  assign busy          = (state_r != LOAD);
  assign core_in       = core_in_r;

endmodule
